// File: rtl/code2421_to_ex3_serial_pkg.sv
// Shared definitions for the 2421 -> Excess-3 digit-serial decoder.
//  - 2421 code points for digits 0-9 (codes 1000-1101 are unused/invalid)
//  - Excess-3 bias
//  - FSM state encoding
package code2421_pkg;

  localparam logic [3:0] C2421_0 = 4'b0000;
  localparam logic [3:0] C2421_1 = 4'b0001;
  localparam logic [3:0] C2421_2 = 4'b0010;
  localparam logic [3:0] C2421_3 = 4'b0011;
  localparam logic [3:0] C2421_4 = 4'b0100;
  localparam logic [3:0] C2421_5 = 4'b0101;
  localparam logic [3:0] C2421_6 = 4'b0110;
  localparam logic [3:0] C2421_7 = 4'b0111;
  localparam logic [3:0] C2421_8 = 4'b1110;
  localparam logic [3:0] C2421_9 = 4'b1111;

  localparam logic [3:0] EX3_BIAS = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/code2421_to_ex3_serial_if.sv
// Handshake bundle for the 2421 -> Excess-3 serial decoder.
//  master: word producer / result consumer (drives in_valid, in_data, out_ready)
//  slave : the decoder (drives in_ready, out_valid, out_data, out_err, out_any_err, busy)
interface code2421_to_ex3_serial_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [4*NUM_DIGITS-1:0]   in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [4*NUM_DIGITS-1:0]   out_data;
  logic [NUM_DIGITS-1:0]     out_err;
  logic                      out_any_err;
  logic                      busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_any_err, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err, out_any_err, busy
  );
endinterface

// File: rtl/code2421_to_ex3_digit.sv
// Combinational single-digit decode: 2421 code -> Excess-3 code.
//  code : 2421 digit
//  ex3  : digit + 3, or 0000 when the code is invalid
//  err  : 1 when code is one of 1000-1101
module code2421_to_ex3_digit
  import code2421_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] ex3,
  output logic       err
);
  always_comb begin
    ex3 = 4'd0;
    err = 1'b0;
    // Below 8 the 2421 weights match plain binary, so only 8/9 need mapping.
    if (!code[3])
      ex3 = code + EX3_BIAS;
    else if (code == C2421_8)
      ex3 = 4'd8 + EX3_BIAS;
    else if (code == C2421_9)
      ex3 = 4'd9 + EX3_BIAS;
    else
      err = 1'b1;
  end
endmodule

// File: rtl/code2421_to_ex3_serial.sv
// Digit-serial 2421 -> Excess-3 decoder, LS digit first, one digit per cycle.
//  clk, rst_n : clock, synchronous active-low reset
//  bus (slave): in_valid/in_ready/in_data word input, out_valid/out_ready result
//               output with out_data, per-digit out_err, out_any_err, and busy.
// A word is accepted in IDLE, decoded over NUM_DIGITS cycles in CONV, and held
// in DONE until the consumer takes it. Results stay visible in IDLE until the
// next capture clears them.
module code2421_to_ex3_serial
  import code2421_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  code2421_to_ex3_serial_if.slave bus
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  state_t                state, state_nxt;
  logic [W-1:0]          shift;
  logic [W-1:0]          res;
  logic [NUM_DIGITS-1:0] err;
  logic [CW-1:0]         cnt;
  logic                  last;
  logic [3:0]            d_ex3;
  logic                  d_err;
  logic                  in_ready, out_valid, busy;

  assign last = (cnt == LAST);

  code2421_to_ex3_digit u_digit (
    .code (shift[3:0]),
    .ex3  (d_ex3),
    .err  (d_err)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = CONV;
      CONV:    if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      CONV:    busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // datapath: capture, then decode the low nibble into slot cnt each cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift <= '0;
      res   <= '0;
      err   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          shift <= bus.in_data;
          res   <= '0;
          err   <= '0;
          cnt   <= '0;
        end
        CONV: begin
          shift <= shift >> 4;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cnt == CW'(i)) begin
              res[4*i +: 4] <= d_ex3;
              err[i]        <= d_err;
            end
          end
          // cnt parks on the last slot; the next capture restarts it
          if (!last) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.busy        = busy;
  assign bus.out_data    = res;
  assign bus.out_err     = err;
  assign bus.out_any_err = |err;

endmodule

// File: tb/tb_code2421_to_ex3_serial.sv
// Directed bench: 4-digit instance for the main scenarios, 1-digit instance
// for the full code sweep.
module tb_code2421_to_ex3_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  code2421_to_ex3_serial_if #(.NUM_DIGITS(4)) bus4 ();
  code2421_to_ex3_serial_if #(.NUM_DIGITS(1)) bus1 ();

  code2421_to_ex3_serial #(.NUM_DIGITS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  code2421_to_ex3_serial #(.NUM_DIGITS(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept one word on bus4, return cycles from accepting edge to out_valid
  task automatic send4(input logic [15:0] d, output int lat);
    bus4.in_data  = d;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.in_data = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.in_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    n_checks++; if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus4.in_ready); end
    n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus4.out_valid); end
    n_checks++; if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus4.busy); end
    n_checks++; if (bus4.out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got %h exp 0000", bus4.out_data); end
    n_checks++; if (bus4.out_err !== 4'b0000) begin n_fail++; $display("FAIL reset_out_err got %b exp 0000", bus4.out_err); end
    n_checks++; if (bus4.out_any_err !== 1'b0) begin n_fail++; $display("FAIL reset_any_err got %b exp 0", bus4.out_any_err); end
  endtask

  task automatic test_basic();
    int lat;
    bus4.out_ready = 1'b1;
    send4(16'hFE50, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got %0d exp 4", lat); end
    n_checks++; if (bus4.out_data !== 16'hCB83) begin n_fail++; $display("FAIL basic_data got %h exp CB83", bus4.out_data); end
    n_checks++; if (bus4.out_err !== 4'b0000) begin n_fail++; $display("FAIL basic_err got %b exp 0000", bus4.out_err); end
    n_checks++; if (bus4.out_any_err !== 1'b0) begin n_fail++; $display("FAIL basic_any_err got %b exp 0", bus4.out_any_err); end
    tick();
    n_checks++; if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_back_idle got %b exp 1", bus4.in_ready); end
    n_checks++; if (bus4.out_data !== 16'hCB83) begin n_fail++; $display("FAIL basic_idle_hold got %h exp CB83", bus4.out_data); end
  endtask

  task automatic test_invalid();
    int lat;
    bus4.out_ready = 1'b1;
    send4(16'h0A07, lat);
    n_checks++; if (bus4.out_data !== 16'h303A) begin n_fail++; $display("FAIL inv_data got %h exp 303A", bus4.out_data); end
    n_checks++; if (bus4.out_err !== 4'b0100) begin n_fail++; $display("FAIL inv_err got %b exp 0100", bus4.out_err); end
    n_checks++; if (bus4.out_any_err !== 1'b1) begin n_fail++; $display("FAIL inv_any_err got %b exp 1", bus4.out_any_err); end
    tick();
  endtask

  task automatic test_sweep_nd1();
    logic [3:0] exp_ex3 [16] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB, 4'hC};
    logic       exp_err [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
    int lat;
    bus1.out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus1.in_data  = 4'(c);
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 10) begin tick(); lat++; end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL nd1_latency code %0d got %0d exp 1", c, lat); end
      n_checks++; if (bus1.out_data !== exp_ex3[c]) begin n_fail++; $display("FAIL nd1_data code %0d got %h exp %h", c, bus1.out_data, exp_ex3[c]); end
      n_checks++; if (bus1.out_err !== exp_err[c]) begin n_fail++; $display("FAIL nd1_err code %0d got %b exp %b", c, bus1.out_err, exp_err[c]); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus4.out_ready = 1'b0;
    send4(16'h1234, lat);
    n_checks++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout got %b exp 1", bus4.out_valid); end
    bus4.in_data  = 16'hFFFF;
    bus4.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (bus4.out_data !== 16'h4567) begin n_fail++; $display("FAIL bp_hold_data cyc %0d got %h exp 4567", k, bus4.out_data); end
      n_checks++; if (bus4.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", k, bus4.in_ready); end
      n_checks++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc %0d got %b exp 1", k, bus4.out_valid); end
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    tick();
    n_checks++; if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_idle got %b exp 1", bus4.in_ready); end
    n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b exp 0", bus4.out_valid); end
    tick(); tick();
    n_checks++; if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_word got busy %b exp 0", bus4.busy); end
    n_checks++; if (bus4.out_data !== 16'h4567) begin n_fail++; $display("FAIL bp_idle_hold got %h exp 4567", bus4.out_data); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus4.out_ready = 1'b1;
    bus4.in_data   = 16'hFE50;
    bus4.in_valid  = 1'b1;
    tick();                 // accept, cnt=0
    bus4.in_valid  = 1'b0;
    tick(); tick();         // two digits written, cnt=2
    n_checks++; if (bus4.out_data !== 16'h0083) begin n_fail++; $display("FAIL mid_partial got %h exp 0083", bus4.out_data); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b exp 1", bus4.in_ready); end
    n_checks++; if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", bus4.busy); end
    n_checks++; if (bus4.out_data !== 16'h0000) begin n_fail++; $display("FAIL mid_out_data got %h exp 0000", bus4.out_data); end
    n_checks++; if (bus4.out_err !== 4'b0000) begin n_fail++; $display("FAIL mid_out_err got %b exp 0000", bus4.out_err); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus4.out_valid) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_output got %0d valid cycles exp 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [2];
    int acc_cyc [2];
    int acc_idx, out_idx, cyc;
    logic accept_now;
    got[0] = '0; got[1] = '0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    acc_idx = 0; out_idx = 0; cyc = 0;
    bus4.out_ready = 1'b1;
    bus4.in_data   = 16'h1234;
    bus4.in_valid  = 1'b1;
    while (out_idx < 2 && cyc < 60) begin
      accept_now = bus4.in_ready && bus4.in_valid;
      if (bus4.out_valid) begin got[out_idx] = bus4.out_data; out_idx++; end
      tick();
      cyc++;
      if (accept_now && acc_idx < 2) begin
        acc_cyc[acc_idx] = cyc;
        acc_idx++;
        if (acc_idx == 1) bus4.in_data = 16'h7777;
        else              bus4.in_valid = 1'b0;
      end
    end
    bus4.in_valid = 1'b0;
    n_checks++; if (out_idx !== 2) begin n_fail++; $display("FAIL b2b_timeout got %0d results exp 2", out_idx); end
    n_checks++; if (got[0] !== 16'h4567) begin n_fail++; $display("FAIL b2b_first got %h exp 4567", got[0]); end
    n_checks++; if (got[1] !== 16'hAAAA) begin n_fail++; $display("FAIL b2b_second got %h exp AAAA", got[1]); end
    n_checks++; if (acc_cyc[1] - acc_cyc[0] !== 6) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 6", acc_cyc[1] - acc_cyc[0]); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_sweep_nd1();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
